// File: rtl/sparsemap_match_scan_if.sv
// rtl/sparsemap_match_scan_if.sv - window-in / match-out bundle of the sparsemap match scanner
interface sparsemap_match_scan_if #(
    parameter int PREFIX_SUM_SIZE = 32,
    parameter int WIN_CNT_W       = 16
);
    localparam int AW = $clog2(PREFIX_SUM_SIZE);

    logic                       chunk_start_i;
    logic                       win_valid_i;
    logic                       win_ready_o;
    logic [PREFIX_SUM_SIZE-1:0] ifm_sparsemap_i;
    logic [PREFIX_SUM_SIZE-1:0] flt_sparsemap_i;
    logic                       match_ready_i;
    logic                       match_valid_o;
    logic [AW-1:0]              pri_enc_match_addr_o;
    logic                       pri_enc_end_o;
    logic [PREFIX_SUM_SIZE-1:0] sparsemap_o;
    logic [WIN_CNT_W-1:0]       win_cnt_o;

    // Scanner side.
    modport slave (
        input  chunk_start_i,
        input  win_valid_i,
        output win_ready_o,
        input  ifm_sparsemap_i,
        input  flt_sparsemap_i,
        input  match_ready_i,
        output match_valid_o,
        output pri_enc_match_addr_o,
        output pri_enc_end_o,
        output sparsemap_o,
        output win_cnt_o
    );

    // Feeder / consumer side.
    modport master (
        output chunk_start_i,
        output win_valid_i,
        input  win_ready_o,
        output ifm_sparsemap_i,
        output flt_sparsemap_i,
        output match_ready_i,
        input  match_valid_o,
        input  pri_enc_match_addr_o,
        input  pri_enc_end_o,
        input  sparsemap_o,
        input  win_cnt_o
    );
endinterface

// File: rtl/sparsemap_match_scan.sv
// rtl/sparsemap_match_scan.sv - ANDs IFM/filter sparsemaps and walks matched bits lowest-first
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 32
`endif

module sparsemap_match_scan #(
    parameter int PREFIX_SUM_SIZE = `PREFIX_SUM_SIZE,
    parameter int WIN_CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sparsemap_match_scan_if.slave bus
);
    localparam int AW = $clog2(PREFIX_SUM_SIZE);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic [PREFIX_SUM_SIZE-1:0] mask_q, mask_d;
    logic [PREFIX_SUM_SIZE-1:0] sparsemap_q, sparsemap_d;
    logic [WIN_CNT_W-1:0]       win_cnt_q, win_cnt_d;

    logic [PREFIX_SUM_SIZE-1:0] mask_rest;
    logic [AW-1:0]              lowest_idx;
    logic                       scan_end;
    logic                       win_done;
    logic                       win_ready;
    logic                       accept;

    // Mask with its lowest set bit removed; zero means at most one bit left.
    assign mask_rest = mask_q & (mask_q - PREFIX_SUM_SIZE'(1));
    assign scan_end  = (state_q == SCAN) && (mask_rest == '0);
    // Current window's last output is consumed this cycle (chunk_start suppresses it).
    assign win_done  = scan_end && bus.match_ready_i && !bus.chunk_start_i;
    // Ready while idle, or when the end beat retires so the next window follows with no bubble.
    assign win_ready = !bus.chunk_start_i && ((state_q == IDLE) || win_done);
    assign accept    = bus.win_valid_i && win_ready;

    // Priority encoder: index of the lowest set mask bit, 0 when empty.
    always_comb begin
        lowest_idx = '0;
        for (int i = PREFIX_SUM_SIZE - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowest_idx = AW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: chunk_start aborts, accept (re)enters SCAN, retired end beat returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.chunk_start_i) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = SCAN;
        end else if (win_done) begin
            state_d = IDLE;
        end
    end

    // FSM outputs: match beat presented only while scanning.
    always_comb begin
        bus.match_valid_o        = 1'b0;
        bus.pri_enc_match_addr_o = '0;
        bus.pri_enc_end_o        = 1'b0;
        if (state_q == SCAN) begin
            bus.match_valid_o        = |mask_q;
            bus.pri_enc_match_addr_o = lowest_idx;
            bus.pri_enc_end_o        = scan_end;
        end
        bus.win_ready_o = win_ready;
        bus.sparsemap_o = sparsemap_q;
        bus.win_cnt_o   = win_cnt_q;
    end

    // Datapath next values: load on accept, strip lowest bit on consume, count finished windows.
    always_comb begin
        mask_d      = mask_q;
        sparsemap_d = sparsemap_q;
        win_cnt_d   = win_cnt_q;
        if (bus.chunk_start_i) begin
            mask_d      = '0;
            sparsemap_d = '0;
            win_cnt_d   = '0;
        end else begin
            if (state_q == SCAN && bus.match_ready_i) begin
                mask_d = mask_rest;
            end
            if (win_done) begin
                win_cnt_d = win_cnt_q + WIN_CNT_W'(1);
            end
            if (accept) begin
                mask_d      = bus.ifm_sparsemap_i & bus.flt_sparsemap_i;
                sparsemap_d = bus.ifm_sparsemap_i;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mask_q      <= '0;
            sparsemap_q <= '0;
            win_cnt_q   <= '0;
        end else begin
            mask_q      <= mask_d;
            sparsemap_q <= sparsemap_d;
            win_cnt_q   <= win_cnt_d;
        end
    end

endmodule

// File: doc/sparsemap_match_scan.md
Name: sparsemap_match_scan

Overview:
Upstream feeder of the data read-address calculator. Accepts one IFM/filter sparsemap window pair, ANDs the two maps, and walks the matched bits lowest-index-first, one per cycle. For each matched bit it emits the bit index (priority-encoder match address), the window-end pulse, and a held copy of the IFM sparsemap. The downstream address stage uses the held IFM map for its prefix sum and to advance its base address. Sits between the sparsemap SRAM read port and the address calculator / MAC issue logic.

Parameters:
PREFIX_SUM_SIZE, `PREFIX_SUM_SIZE (32), window width in bits; power of two, >=4
WIN_CNT_W, 16, width of the per-chunk window counter

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous assert, active-low (0 = reset)
chunk_start_i  in  1  synchronous clear: abort scan, zero counters
win_valid_i  in  1  new window pair offered
win_ready_o  out  1  window accepted when win_valid_i && win_ready_o
ifm_sparsemap_i  in  PREFIX_SUM_SIZE  IFM nonzero map of offered window
flt_sparsemap_i  in  PREFIX_SUM_SIZE  filter nonzero map of offered window
match_ready_i  in  1  downstream consumes current match/end this cycle
match_valid_o  out  1  pri_enc_match_addr_o holds a real matched index
pri_enc_match_addr_o  out  $clog2(PREFIX_SUM_SIZE)  index of lowest remaining matched bit
pri_enc_end_o  out  1  last output of current window (with or without match)
sparsemap_o  out  PREFIX_SUM_SIZE  registered IFM map of window being scanned
win_cnt_o  out  WIN_CNT_W  windows completed since chunk start

Behaviour:
- Reset (rst_i=0, async): state IDLE; match_valid_o=0, pri_enc_end_o=0, pri_enc_match_addr_o=0, sparsemap_o=0, win_cnt_o=0, win_ready_o=1 once rst_i released. Internal mask register = 0.
- States: IDLE, SCAN.
- win_ready_o = (state==IDLE) || (state==SCAN && pri_enc_end_o && match_ready_i). This gives back-to-back windows with no bubble.
- On accept: mask <= ifm & flt; sparsemap_o <= ifm; state <= SCAN. First output appears the cycle after accept (latency 1).
- In SCAN, outputs are combinational from registered mask:
  - match_valid_o = |mask.
  - pri_enc_match_addr_o = index of lowest set bit, or 0 if mask empty.
  - pri_enc_end_o = popcount(mask) <= 1.
  - An empty match window yields exactly one cycle with match_valid_o=0 and pri_enc_end_o=1, so downstream still advances its base address.
- Advance on match_ready_i: clear lowest set bit of mask (mask & (mask-1)). If pri_enc_end_o, then win_cnt_o += 1 (wraps at 2^WIN_CNT_W) and state <= IDLE, unless a new window is accepted the same cycle (state stays SCAN, mask/sparsemap_o reload).
- Backpressure: while match_ready_i=0, all outputs hold stable.
- sparsemap_o is held from accept through the end cycle; it is unchanged in IDLE.
- In IDLE: match_valid_o=0, pri_enc_end_o=0.
- chunk_start_i (priority over everything except reset): mask<=0, state<=IDLE, win_cnt_o<=0; any window offered that cycle is not accepted (win_ready_o forced 0 that cycle); sparsemap_o<=0.
- Reset mid-scan: immediate return to reset values; no end pulse is emitted for the aborted window.
- Full map (all bits matched): PREFIX_SUM_SIZE consecutive outputs, indices 0..PREFIX_SUM_SIZE-1, end on the last.
- Bit PREFIX_SUM_SIZE-1 alone: single output, index max, end=1.

Test Plan:
- PREFIX_SUM_SIZE=8; ifm=8'b1011_0110, flt=8'b1110_0011, match_ready_i=1 -> outputs (addr,valid,end): (1,1,0),(5,1,0),(7,1,1); sparsemap_o=8'hB6 throughout; win_cnt_o 0->1.
- ifm=8'h0F, flt=8'hF0 -> one cycle valid=0,end=1,addr=0; win_cnt_o increments; win_ready_o high that cycle.
- Back-to-back: window A (match 8'h81) and B (match 8'h02) offered continuously -> addr 0,7(end),1(end) on consecutive cycles, no bubble; sparsemap_o switches the cycle after A's end.
- Backpressure: match 8'h0C, match_ready_i low for 3 cycles after first output -> addr=2 held 4 cycles, then 3 with end; no index skipped or repeated.
- chunk_start_i asserted during second output of match 8'hFF -> next cycle IDLE, valid=0, end=0, win_cnt_o=0, sparsemap_o=0; a fresh window scans normally afterwards.
- rst_i pulled low asynchronously mid-scan (between clock edges) -> outputs go to reset values immediately; after release, first window produces correct index sequence.
